inst_mem_loader: RTL
====================

// Module: inst_mem_loader
// PURPOSE
//  Write-side companion to the instruction memory. Accepts 32-bit instruction words over a
//  valid/ready stream and writes each word into the byte-wide instruction store as 4 byte writes.
//  Byte order is little-endian, so a later fetch of {M[a+3],M[a+2],M[a+1],M[a]} returns the word.
//  Sits between a host/boot source and the instruction memory write port; runs before CPU release.
// PARAMETERS
//  ADDR_WIDTH  64   width of mem_addr, matches the 64-bit instruction address bus
//  MEM_BYTES   128  capacity of the instruction store in bytes; must be a multiple of 4
//  BASE_ADDR   0    byte address of the first word written after start
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high reset
//  start        in   1           1-cycle pulse: begin a load session at BASE_ADDR
//  word_in      in   32          instruction word to store
//  word_valid   in   1           word_in is valid
//  word_last    in   1           qualifies word_in as the final word of the session
//  word_ready   out  1           loader can accept a word this cycle
//  mem_we       out  1           byte write enable to instruction store
//  mem_addr     out  ADDR_WIDTH  byte address of the current write
//  mem_wdata    out  8           byte data of the current write
//  busy         out  1           session in progress (not IDLE/DONE)
//  done         out  1           session finished; held until next start or reset
//  overflow     out  1           word offered with store full; sticky until start/reset
//  words_loaded out  ADDR_WIDTH-2 count of complete words written this session
// BEHAVIOUR
//  Reset (sync): state=IDLE; all outputs 0; latched word, byte index, address, count cleared.
//  Reset mid-write aborts immediately: no further mem_we, and partial words are not counted.
//  FSM states: IDLE, WAIT_WORD, WRITE, DONE.
//   IDLE: word_ready=0. start -> WAIT_WORD; addr<=BASE_ADDR, words_loaded<=0, overflow<=0.
//   WAIT_WORD: busy=1, word_ready=1. On word_valid&word_ready: latch word_in and word_last,
//    byte_idx<=0, go to WRITE. If addr==BASE_ADDR+MEM_BYTES (full), hold word_ready=0 instead.
//    A word_valid in the full condition sets overflow=1 and moves the FSM to DONE; no write occurs.
//   WRITE: busy=1, word_ready=0, mem_we=1, mem_addr=addr+byte_idx, mem_wdata=word[8*byte_idx+:8].
//    byte_idx counts 0..3 (little-endian: byte0=word[7:0] at addr). At byte_idx==3:
//    addr<=addr+4, words_loaded++. If last latched -> DONE, else -> WAIT_WORD.
//   DONE: busy=0, done=1, word_ready=0. start -> WAIT_WORD (same actions as from IDLE; done<=0).
//  Latency: handshake in cycle N gives byte writes in cycles N+1..N+4 and word_ready=1 in N+5.
//   Throughput is 1 word per 5 cycles. mem_we is never high outside WRITE.
//  start is ignored while busy. word_valid is ignored in IDLE/DONE (no overflow flagged).
//  Address arithmetic is ADDR_WIDTH-wide unsigned. Store-full check uses the byte address, so
//   exactly MEM_BYTES/4 words fit. With defaults, the 32nd word ends at addr 127.
//  word_in, word_last are sampled only on the accepting edge; later changes do not affect the write.
// TESTING
//  1 reset; start; send 0x00000B33 (last=1) -> we at addr 0..3, data 33,0B,00,00; then done=1, words_loaded=1.
//  2 send 3 words back-to-back, valid held high -> ready pulses every 5 cycles; final addr 11; words_loaded=3.
//  3 send 32 words, last never set, then a 33rd -> 128 byte writes, 33rd not written; overflow=1, done=1.
//  4 assert reset while byte_idx=2 -> next cycle mem_we=0, outputs 0, state IDLE; memory bytes 0..1 only.
//  5 start pulsed during WRITE -> ignored; write completes at the same addresses with no restart.
//  6 after done, start again, send 0xFE0000E3 (last) -> bytes E3,00,00,FE at addr 0..3; done clears then sets.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction store as four
// little-endian byte writes, one word per five cycles, until the last word or the store is full.
module inst_mem_loader #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           MEM_BYTES  = 128,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           word_in,
  input  logic                  word_valid,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-3:0] words_loaded,
  output logic [1:0]            dbg_state
);

  // Handshake: a word transfers on a rising edge where word_valid and word_ready are both 1;
  // word_ready never depends on word_valid, and word_in/word_last are sampled only on that edge.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] END_ADDR = BASE_ADDR + ADDR_WIDTH'(MEM_BYTES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           word_q, word_d;
  logic                  last_q, last_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-3:0] words_q, words_d;
  logic                  ovf_q, ovf_d;
  logic                  full;

  assign full         = (addr_q == END_ADDR);
  assign overflow     = ovf_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    last_d     = last_q;
    idx_d      = idx_q;
    words_d    = words_q;
    ovf_d      = ovf_q;
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_WORD;
          addr_d  = BASE_ADDR;
          words_d = '0;
          ovf_d   = 1'b0;
        end
      end

      WAIT_WORD: begin
        busy       = 1'b1;
        word_ready = !full;
        if (word_valid) begin
          if (full) begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            word_d  = word_in;
            last_d  = word_last;
            idx_d   = '0;
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        busy      = 1'b1;
        // Gated by reset so an abort suppresses the write of the current cycle too.
        mem_we    = !reset;
        mem_addr  = addr_q + ADDR_WIDTH'(idx_q);
        mem_wdata = word_q[{idx_q, 3'b000} +: 8];
        idx_d     = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          addr_d  = addr_q + ADDR_WIDTH'(4);
          words_d = words_q + (ADDR_WIDTH-2)'(1);
          state_d = last_q ? DONE : WAIT_WORD;
        end
      end

      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = WAIT_WORD;
          addr_d  = BASE_ADDR;
          words_d = '0;
          ovf_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
